// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Port indices, memory command encodings and FSM states.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_ISSUE,
        READ_WAIT
    } arb_state_t;

    localparam int PORT_ST    = 0;
    localparam int PORT_LD    = 1;
    localparam int RD_LAT_MAX = 3;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-requester round-robin pick with its own priority pointer.
// ptr = 0 favours requester 0, ptr = 1 favours requester 1.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (1'b1)
                (req == 2'b01): gnt = 2'b01;
                (req == 2'b10): gnt = 2'b10;
                (req == 2'b11): gnt = ptr ? 2'b10 : 2'b01;
                default:        gnt = 2'b00;
            endcase
        end
    end

    // Every grant moves priority to the other side, contested or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Load/store share of the single-port data BRAM.
// One access in flight; all outputs come straight from flops.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_wdata,
    input  logic [3:0]        st_byte_en,
    output logic              st_gnt,
    output logic              mem_en,
    output logic              mem_rw_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_byte_en,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("dmem_port_arbiter: RD_LAT must be 1..3");
    end

    localparam logic [1:0] LAT = 2'(RD_LAT);

    arb_state_t        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        arb_gnt;
    logic              ld_gnt_d, ld_rvalid_d, st_gnt_d;
    logic [DATA_W-1:0] ld_rdata_d;
    logic              mem_en_d, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [3:0]        mem_be_d;

    rr_arb2 u_rr (
        .clk (i_clk),
        .rst (i_rst),
        .en  (state_q == IDLE),
        .req ({ld_req, st_req}),
        .gnt (arb_gnt)
    );

    // Next-state logic also computes next outputs, so the
    // memory command appears in the cycle the FSM enters a state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_gnt_d    = 1'b0;
        ld_rvalid_d = 1'b0;
        ld_rdata_d  = ld_rdata;
        st_gnt_d    = 1'b0;
        mem_en_d    = 1'b0;
        mem_rw_d    = MEM_RD;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_be_d    = 4'b0000;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    arb_gnt[PORT_ST]: begin
                        state_d     = WRITE;
                        st_gnt_d    = 1'b1;
                        mem_en_d    = 1'b1;
                        mem_rw_d    = MEM_WR;
                        mem_addr_d  = st_addr;
                        mem_wdata_d = st_wdata;
                        mem_be_d    = st_byte_en;
                    end
                    arb_gnt[PORT_LD]: begin
                        state_d    = READ_ISSUE;
                        ld_gnt_d   = 1'b1;
                        mem_en_d   = 1'b1;
                        mem_rw_d   = MEM_RD;
                        mem_addr_d = ld_addr;
                    end
                    default: ;
                endcase
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ_ISSUE: begin
                state_d = READ_WAIT;
                cnt_d   = LAT;
            end
            READ_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d     = IDLE;
                    ld_rvalid_d = 1'b1;
                    ld_rdata_d  = mem_read_data;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= IDLE;
            cnt_q          <= 2'd0;
            ld_gnt         <= 1'b0;
            ld_rvalid      <= 1'b0;
            ld_rdata       <= '0;
            st_gnt         <= 1'b0;
            mem_en         <= 1'b0;
            mem_rw_mode    <= MEM_RD;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_byte_en    <= 4'b0000;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ld_gnt         <= ld_gnt_d;
            ld_rvalid      <= ld_rvalid_d;
            ld_rdata       <= ld_rdata_d;
            st_gnt         <= st_gnt_d;
            mem_en         <= mem_en_d;
            mem_rw_mode    <= mem_rw_d;
            mem_addr       <= mem_addr_d;
            mem_write_data <= mem_wdata_d;
            mem_byte_en    <= mem_be_d;
            busy           <= (state_d != IDLE);
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (10-bit word address, 32-bit data, 4-bit byte enables) between the load unit and the store unit.
- Each requester issues one access per req/gnt handshake. The arbiter grants one at a time, drives the memory command, and returns read data to the load unit after the memory read latency.
- Sits between the execute-stage load/store units and the data BRAM. It owns every data-memory control line.

Parameters:
- ADDR_W, 10, word address width (byte address bits [11:2])
- DATA_W, 32, data width
- RD_LAT, 1, memory read latency in cycles; legal 1..3

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- ld_req  input  1  load access request (level)
- ld_addr  input  ADDR_W  load word address
- ld_gnt  output  1  load command issued this cycle (1-cycle pulse)
- ld_rvalid  output  1  ld_rdata valid (1-cycle pulse)
- ld_rdata  output  DATA_W  read word
- st_req  input  1  store access request (level)
- st_addr  input  ADDR_W  store word address
- st_wdata  input  DATA_W  store data, already lane-aligned
- st_byte_en  input  4  store byte lanes
- st_gnt  output  1  store written this cycle (1-cycle pulse)
- mem_en  output  1  memory access enable
- mem_rw_mode  output  1  1 = write, 0 = read
- mem_addr  output  ADDR_W  memory word address
- mem_write_data  output  DATA_W  memory write data
- mem_byte_en  output  4  memory byte enables
- mem_read_data  input  DATA_W  memory read data, valid RD_LAT cycles after the read command
- busy  output  1  FSM not IDLE

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous, active-high. All outputs are registered.
- Reset values:
  - state = IDLE, rr_ptr = 0 (store favoured).
  - All outputs 0, including ld_rdata.
- States: IDLE, WRITE, READ_ISSUE, READ_WAIT.
- IDLE:
  - Neither req: stay in IDLE.
  - Only st_req: go to WRITE.
  - Only ld_req: go to READ_ISSUE.
  - Both: rr_ptr=0 goes to WRITE, rr_ptr=1 goes to READ_ISSUE.
  - Payload (addr/wdata/byte_en) is captured on the transition.
  - rr_ptr is updated on every grant, contested or not: 1 after a store grant, 0 after a load grant.
- WRITE (1 cycle):
  - mem_en=1, mem_rw_mode=1, mem_addr/mem_write_data/mem_byte_en = captured store payload, st_gnt=1.
  - Next state IDLE.
- READ_ISSUE (1 cycle):
  - mem_en=1, mem_rw_mode=0, mem_addr=captured ld_addr, ld_gnt=1.
  - mem_write_data and mem_byte_en are 0.
  - Load counter to RD_LAT; next state READ_WAIT.
- READ_WAIT:
  - All mem_* outputs are 0.
  - Counter decrements each cycle. In the cycle it reaches 0, mem_read_data is captured into ld_rdata and ld_rvalid=1 in the following cycle.
  - The FSM returns to IDLE in the same cycle ld_rvalid is asserted.
  - ld_rdata holds its value until the next capture.
- Timing: with the read command in cycle N, ld_rvalid is in cycle N+RD_LAT+1.
  - Store occupancy: 2 cycles.
  - Load occupancy: RD_LAT+2 cycles.
- Whenever mem_en=0, all other mem_* outputs are 0.
- Requester rule:
  - Hold req and payload stable until gnt.
  - Deassert req on the clock edge that ends the gnt cycle.
  - The load unit issues no new ld_req before ld_rvalid.
  - The arbiter samples requests only in IDLE.
- Boundary cases:
  - st_byte_en = 0: still granted; a write with mem_byte_en=0 is issued (no-op write).
  - st_req arriving during a read: waits until IDLE and is then granted ahead of a new ld_req only if rr_ptr=0.
  - Continuous demand from both ports: strict alternation; neither port is granted twice while the other waits.
  - Reset mid-operation: the transaction is dropped. No gnt/rvalid pulse follows and mem_en=0 in the next cycle. The requester re-issues.
  - RD_LAT outside 1..3: elaboration error.

Decomposition:
- Package dmem_arb_pkg:
  - state enum: IDLE, WRITE, READ_ISSUE, READ_WAIT
  - PORT_ST=0, PORT_LD=1
  - RD_LAT_MAX=3
  - mem_rw_mode encodings MEM_RD=0, MEM_WR=1
- Sub-module rr_arb2: two-requester round-robin pick plus rr_ptr register, reusable for a later instruction/data port share.

Test Plan:
- Lone store: st_req, st_addr=0x004, st_wdata=0xDEADBEEF, st_byte_en=4'b1111 at cycle 0 -> cycle 1: mem_en=1, mem_rw_mode=1, mem_addr=0x004, data 0xDEADBEEF, st_gnt=1 for exactly one cycle; cycle 2: mem_* all 0.
- Lone load, RD_LAT=1: ld_req, ld_addr=0x010, memory returns 0x12345678 -> cycle 1: ld_gnt=1, mem_en=1, mem_rw_mode=0; cycle 3: ld_rvalid=1, ld_rdata=0x12345678; busy low in cycle 4.
- Tie after reset: st_req and ld_req both high at cycle 0 -> store granted first (st_gnt cycle 1), load issued cycle 3; a second simultaneous pair then grants load first.
- Store while read outstanding, RD_LAT=3: st_req raised in cycle 2 of a load -> no st_gnt until after ld_rvalid; st_gnt in the first WRITE cycle after IDLE.
- Reset mid-read: assert i_rst during READ_WAIT -> no ld_rvalid, all outputs 0 the next cycle, state IDLE, rr_ptr=0.
- Continuous contention over 8 grants: grant sequence strictly alternates ST,LD,ST,LD…; partial store st_byte_en=4'b0100 appears unchanged on mem_byte_en.
